request_control: RTL
====================

# request_control

Request-capture stage directly upstream of the elevator state controller for the 4-storey elevator. Synchronises and edge-detects cab and hall buttons, latches them as pending requests, clears requests at the current floor while the door is open, and produces the registered `allReq_reg`, `up_need` and `down_need` that the state controller consumes. Also drives the button lamp registers.

## Interface
- none: no parameters; floor count is fixed at 4, bit i = floor i+1, one-hot.
- `clk`  in  1  system clock, 32 Hz; all logic on posedge.
- `switch`  in  1  elevator master switch, used as the synchronous active-low reset; `switch`=0 at a posedge resets the block.
- `cab_btn`  in  4  cab floor buttons, raw level, asynchronous.
- `hall_up`  in  3  hall up buttons for floors 1–3; bit i = floor i+1.
- `hall_dn`  in  3  hall down buttons for floors 2–4; bit i = floor i+2.
- `position`  in  4  current floor, one-hot, from the state controller.
- `opendoor`  in  1  door-open command from the state controller.
- `allReq_reg`  out  4  pending-request mask per floor.
- `up_need`  out  1  a pending request exists strictly above `position`.
- `down_need`  out  1  a pending request exists strictly below `position`.
- `cab_lamp`  out  4  pending cab requests.
- `up_lamp`  out  3  pending hall-up requests.
- `dn_lamp`  out  3  pending hall-down requests.

## Operation
- Each of the 10 button inputs passes through 2 flops (`s1`, `s2`) plus a history flop (`prev`). `rise` = `s2` & ~`prev`. Only rising edges set requests; holding a button sets its request once.
- Request registers `cab_r[3:0]`, `up_r[2:0]`, `dn_r[2:0]`:
  - Set: the bit is set on `rise`.
  - Clear: when `opendoor`=1, every request whose floor equals `position` is cleared. This covers the cab request, the hall-up request and the hall-down request at that floor.
  - Priority: clear beats set in the same cycle. A press at the open floor is absorbed.
- Floor mask: `floor_req[i]` = `cab_r[i]` | `up_r[i]` (i ≤ 2) | `dn_r[i-1]` (i ≥ 1).
- `allReq_reg` is a register loaded with `floor_req` every cycle.
- `up_need` and `down_need` are registers:
  - `up_need` is loaded with |(`allReq_reg` & above(`position`)).
  - `down_need` is loaded with |(`allReq_reg` & below(`position`)).
  - above(0001)=1110, above(0010)=1100, above(0100)=1000, above(1000)=0000. below(p) is the mirror of above(p).
  - If `position` is not one-hot, both needs are loaded with 0.
- Lamps are wired directly to `cab_r`, `up_r` and `dn_r`.
- `switch`=0 at a posedge clears all synchronisers, history flops, request registers and outputs.
  - This applies mid-operation: pending requests are discarded.
  - A button held through reset release is seen as a new rise and is registered.

## Timing
- Reset value of every output: 0.
- Press latency, with the button first high at posedge k:
  - `s1` at k, `s2` at k+1.
  - Request register and lamp at k+2.
  - `allReq_reg` at k+3.
  - `up_need`/`down_need` at k+4.
- Clear latency: `opendoor`=1 sampled at posedge k clears the request and lamp at k. `allReq_reg` drops at k+1 and the needs update at k+2.
- `position` change sampled at k is reflected in the needs at k+1.
- Simultaneous events:
  - Presses on several buttons in one cycle are all captured.
  - Set and clear on the same bit in the same cycle leaves the bit at 0.
- No handshake: outputs are level signals valid every cycle.

## Test plan
- Reset: `switch`=0 with all buttons pulsed → all outputs 0. After `switch`=1, floor-3 cab held high from posedge k → `cab_lamp`=0100 at k+2, `allReq_reg`=0100 at k+3.
- Direction: `position`=0010, requests on floors 1 and 4 (`cab_btn` bit0, `hall_dn` bit2) → `allReq_reg`=1001, `up_need`=1, `down_need`=1, `dn_lamp`=100.
- Service clear: `position`=0100, `up_r`[2]=1 and `cab_r`[2]=1, `opendoor`=1 → both cleared that cycle. `allReq_reg`[2]=0 on the next cycle; `up_need` goes to 0 if no higher requests remain.
- Clear wins: `opendoor`=1 at floor 1 while a `cab_btn`[0] rise arrives in the same cycle → `cab_lamp`[0] stays 0.
- Held button: `hall_up`[0] held for 20 cycles, cleared by `opendoor` at floor 1 at cycle 10 → request not re-set while held; a new press after release re-sets it.
- Bad position: `position`=0110 with requests pending → `up_need`=`down_need`=0; `allReq_reg` unaffected.

Source files
------------

// File: rtl/request_control_if.sv
// Button, position and request-status signals exchanged between the
// request-capture stage and its surroundings (buttons, state controller,
// lamp drivers). The block itself connects through the slave modport.
interface request_control_if;
  // raw buttons (asynchronous levels)
  logic [3:0] cab_btn;
  logic [2:0] hall_up;   // bit i = floor i+1
  logic [2:0] hall_dn;   // bit i = floor i+2
  // from the state controller
  logic [3:0] position;  // one-hot current floor
  logic       opendoor;
  // request status
  logic [3:0] allReq_reg;
  logic       up_need;
  logic       down_need;
  // lamps
  logic [3:0] cab_lamp;
  logic [2:0] up_lamp;
  logic [2:0] dn_lamp;

  modport master (
    output cab_btn, hall_up, hall_dn, position, opendoor,
    input  allReq_reg, up_need, down_need, cab_lamp, up_lamp, dn_lamp
  );

  modport slave (
    input  cab_btn, hall_up, hall_dn, position, opendoor,
    output allReq_reg, up_need, down_need, cab_lamp, up_lamp, dn_lamp
  );
endinterface

// File: rtl/request_control.sv
// Request-capture stage for a 4-storey elevator: synchronises and
// edge-detects the 10 buttons, latches pending requests, clears the
// requests of the current floor while the door is open, and registers the
// per-floor request mask plus up/down "need" flags for the state controller.
module request_control (
  input logic           clk,
  input logic           switch,   // master switch, synchronous active-low reset
  request_control_if.slave bus
);

  // Bit layout of the flattened button vector:
  //   [3:0] cab floors 1-4, [6:4] hall up floors 1-3, [9:7] hall down floors 2-4
  logic [9:0] btn_raw;
  logic [9:0] s1_reg;
  logic [9:0] s2_reg;
  logic [9:0] prev_reg;
  logic [9:0] rise;

  assign btn_raw = {bus.hall_dn, bus.hall_up, bus.cab_btn};

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_btn
      // Two-flop synchroniser plus history flop for rising-edge detection
      always_ff @(posedge clk) begin
        if (!switch) begin
          s1_reg[gi]   <= 1'b0;
          s2_reg[gi]   <= 1'b0;
          prev_reg[gi] <= 1'b0;
        end else begin
          s1_reg[gi]   <= btn_raw[gi];
          s2_reg[gi]   <= s1_reg[gi];
          prev_reg[gi] <= s2_reg[gi];
        end
      end
      assign rise[gi] = s2_reg[gi] & ~prev_reg[gi];
    end
  endgenerate

  logic [3:0] cab_req_reg, cab_req_next;
  logic [2:0] up_req_reg,  up_req_next;
  logic [2:0] dn_req_reg,  dn_req_next;
  logic [3:0] cab_clr;
  logic [2:0] up_clr;
  logic [2:0] dn_clr;
  logic [3:0] floor_req;

  // Clear masks: every request belonging to the open-door floor. Hall-down
  // bit i lives on floor i+2, hence the shifted position slice.
  assign cab_clr = {4{bus.opendoor}} & bus.position;
  assign up_clr  = {3{bus.opendoor}} & bus.position[2:0];
  assign dn_clr  = {3{bus.opendoor}} & bus.position[3:1];

  // Set on rise, clear at the open floor; clear is applied last so it wins
  always_comb begin
    cab_req_next = (cab_req_reg | rise[3:0]) & ~cab_clr;
    up_req_next  = (up_req_reg  | rise[6:4]) & ~up_clr;
    dn_req_next  = (dn_req_reg  | rise[9:7]) & ~dn_clr;
  end

  // Request register state
  always_ff @(posedge clk) begin
    if (!switch) begin
      cab_req_reg <= 4'b0;
      up_req_reg  <= 3'b0;
      dn_req_reg  <= 3'b0;
    end else begin
      cab_req_reg <= cab_req_next;
      up_req_reg  <= up_req_next;
      dn_req_reg  <= dn_req_next;
    end
  end

  assign floor_req = cab_req_reg | {1'b0, up_req_reg} | {dn_req_reg, 1'b0};

  logic [3:0] above_mask;
  logic [3:0] below_mask;

  // Floors strictly above / below the current floor; a non-one-hot position
  // yields empty masks so both needs drop to 0
  always_comb begin
    above_mask = 4'b0000;
    below_mask = 4'b0000;
    case (bus.position)
      4'b0001: begin above_mask = 4'b1110; below_mask = 4'b0000; end
      4'b0010: begin above_mask = 4'b1100; below_mask = 4'b0001; end
      4'b0100: begin above_mask = 4'b1000; below_mask = 4'b0011; end
      4'b1000: begin above_mask = 4'b0000; below_mask = 4'b0111; end
      default: begin above_mask = 4'b0000; below_mask = 4'b0000; end
    endcase
  end

  logic [3:0] all_req_reg;
  logic       up_need_reg;
  logic       down_need_reg;

  // Registered request mask and direction needs (needs look at the
  // already-registered mask, giving one extra stage of latency)
  always_ff @(posedge clk) begin
    if (!switch) begin
      all_req_reg   <= 4'b0;
      up_need_reg   <= 1'b0;
      down_need_reg <= 1'b0;
    end else begin
      all_req_reg   <= floor_req;
      up_need_reg   <= |(all_req_reg & above_mask);
      down_need_reg <= |(all_req_reg & below_mask);
    end
  end

  assign bus.allReq_reg = all_req_reg;
  assign bus.up_need    = up_need_reg;
  assign bus.down_need  = down_need_reg;
  assign bus.cab_lamp   = cab_req_reg;
  assign bus.up_lamp    = up_req_reg;
  assign bus.dn_lamp    = dn_req_reg;

endmodule
